// File: rtl/rsa_operand_sequencer.sv
// rtl/rsa_operand_sequencer.sv - operand loader, core launcher and result sender for the RSA UART datapath
// Optional inter-word timeout: define RSA_OPSEQ_TIMEOUT_EN.
module rsa_operand_sequencer #(
    parameter int N              = 32,
    parameter int bitLen         = 64,
    parameter int WORDS_LOG2     = 1,
    parameter int TIMEOUT_CYCLES = 12000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      word_in,
    input  logic              word_in_valid,
    output logic [bitLen-1:0] core_base,
    output logic [bitLen-1:0] core_exp,
    output logic [bitLen-1:0] core_mod,
    output logic              core_start,
    input  logic              core_done,
    input  logic [bitLen-1:0] core_result,
    output logic [N-1:0]      word_out,
    output logic              word_out_valid,
    input  logic              word_out_ready,
    output logic              busy,
    output logic              overrun,
    output logic              frame_error
);

    localparam int WORDS = bitLen / N;
    localparam logic [WORDS_LOG2-1:0] LAST = WORDS_LOG2'(WORDS - 1);

    typedef enum logic [2:0] {
        LOAD_BASE,
        LOAD_EXP,
        LOAD_MOD,
        START,
        WAIT,
        SEND
    } state_t;

    state_t                state, state_d;
    logic [WORDS_LOG2-1:0] cnt;
    logic [bitLen-1:0]     base_q, exp_q, mod_q, result_q;
    logic                  in_load, last_word, xfer, timeout_hit;

    assign in_load   = (state == LOAD_BASE) || (state == LOAD_EXP) || (state == LOAD_MOD);
    assign last_word = (cnt == LAST);
    assign xfer      = (state == SEND) && word_out_valid && word_out_ready;

    assign core_base = base_q;
    assign core_exp  = exp_q;
    assign core_mod  = mod_q;
    // The result register shifts right on each transfer, so the low word is always the one on offer.
    assign word_out  = result_q[N-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD_BASE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            LOAD_BASE: if (word_in_valid && last_word) state_d = LOAD_EXP;
            LOAD_EXP:  if (word_in_valid && last_word) state_d = LOAD_MOD;
            LOAD_MOD:  if (word_in_valid && last_word) state_d = START;
            START:     state_d = WAIT;
            WAIT:      if (core_done) state_d = SEND;
            SEND:      if (xfer && last_word) state_d = LOAD_BASE;
            default:   state_d = LOAD_BASE;
        endcase
        if (timeout_hit) state_d = LOAD_BASE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            base_q         <= '0;
            exp_q          <= '0;
            mod_q          <= '0;
            result_q       <= '0;
            word_out_valid <= 1'b0;
            core_start     <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            core_start <= (state == START);
            overrun    <= word_in_valid && !in_load;
            busy       <= (state_d != LOAD_BASE);

            if (in_load && word_in_valid) begin
                cnt <= last_word ? '0 : cnt + WORDS_LOG2'(1);
                for (int k = 0; k < WORDS; k++) begin
                    if (cnt == WORDS_LOG2'(k)) begin
                        case (state)
                            LOAD_BASE: base_q[k*N +: N] <= word_in;
                            LOAD_EXP:  exp_q[k*N +: N]  <= word_in;
                            default:   mod_q[k*N +: N]  <= word_in;
                        endcase
                    end
                end
            end
            if (timeout_hit) cnt <= '0;

            if (state == WAIT && core_done) begin
                result_q       <= core_result;
                word_out_valid <= 1'b1;
                cnt            <= '0;
            end

            if (xfer) begin
                result_q <= {{N{1'b0}}, result_q[bitLen-1:N]};
                cnt      <= last_word ? '0 : cnt + WORDS_LOG2'(1);
                if (last_word) word_out_valid <= 1'b0;
            end
        end
    end

`ifdef RSA_OPSEQ_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [GAP_W-1:0] gap_cnt;

    // A word arriving in the same cycle as the limit wins over the timeout.
    assign timeout_hit = in_load && !word_in_valid && (gap_cnt == GAP_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt     <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= timeout_hit;
            if (word_in_valid || timeout_hit)
                gap_cnt <= '0;
            else if (in_load && (cnt != '0 || state != LOAD_BASE))
                gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_operand_sequencer.sv
// tb/tb_rsa_operand_sequencer.sv - directed self-checking bench for rsa_operand_sequencer
module tb_rsa_operand_sequencer;

    localparam int N      = 32;
    localparam int BITLEN = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      word_in;
    logic              word_in_valid;
    logic [BITLEN-1:0] core_base, core_exp, core_mod;
    logic              core_start;
    logic              core_done;
    logic [BITLEN-1:0] core_result;
    logic [N-1:0]      word_out;
    logic              word_out_valid;
    logic              word_out_ready;
    logic              busy, overrun, frame_error;

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;

    rsa_operand_sequencer #(
        .N(N), .bitLen(BITLEN), .WORDS_LOG2(1), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .word_in(word_in), .word_in_valid(word_in_valid),
        .core_base(core_base), .core_exp(core_exp), .core_mod(core_mod),
        .core_start(core_start), .core_done(core_done), .core_result(core_result),
        .word_out(word_out), .word_out_valid(word_out_valid), .word_out_ready(word_out_ready),
        .busy(busy), .overrun(overrun), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (word_out_valid && word_out_ready) xfers++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [N-1:0] w);
        word_in       = w;
        word_in_valid = 1'b1;
        tick();
        word_in_valid = 1'b0;
    endtask

    task automatic load6(input logic [N-1:0] b0, b1, e0, e1, m0, m1);
        send_word(b0); send_word(b1);
        send_word(e0); send_word(e1);
        send_word(m0); send_word(m1);
    endtask

    task automatic core_reply(input logic [BITLEN-1:0] r);
        core_result = r;
        core_done   = 1'b1;
        tick();
        core_done   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; word_in = '0; word_in_valid = 1'b0;
        core_done = 1'b0; core_result = '0; word_out_ready = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", word_out_valid, 0);
        chk("rst_start", core_start, 0);
        chk("rst_base", core_base, 0);
        chk("rst_word_out", word_out, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_error", frame_error, 0);
        rst_n = 1'b1;
        tick();

        // Basic load, start latency and back-to-back send
        load6(32'd5, 32'd0, 32'd3, 32'd0, 32'h21, 32'd0);
        chk("basic_start_lat1", core_start, 0);
        chk("basic_busy", busy, 1);
        tick();
        chk("basic_start_lat2", core_start, 1);
        chk("basic_base", core_base, 64'd5);
        chk("basic_exp", core_exp, 64'd3);
        chk("basic_mod", core_mod, 64'h21);
        xfers = 0;
        core_reply(64'h1A);
        chk("basic_start_one_cycle", core_start, 0);
        chk("basic_valid0", word_out_valid, 1);
        chk("basic_word0", word_out, 32'h1A);
        word_out_ready = 1'b1;
        tick();
        chk("basic_valid1", word_out_valid, 1);
        chk("basic_word1", word_out, 32'h0);
        tick();
        word_out_ready = 1'b0;
        chk("basic_valid_end", word_out_valid, 0);
        chk("basic_busy_end", busy, 0);
        chk("basic_xfers", xfers, 2);

        // Backpressure
        load6(32'd7, 32'd0, 32'd2, 32'd0, 32'hB, 32'd0);
        tick(); tick();
        xfers = 0;
        core_reply(64'h1122334455667788);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", word_out_valid, 1);
            chk("bp_hold_word", word_out, 32'h55667788);
            tick();
        end
        word_out_ready = 1'b1;
        tick();
        chk("bp_word1", word_out, 32'h11223344);
        chk("bp_valid1", word_out_valid, 1);
        tick();
        word_out_ready = 1'b0;
        tick(); tick();
        chk("bp_valid_end", word_out_valid, 0);
        chk("bp_xfers", xfers, 2);

        // Overrun in WAIT
        load6(32'd2, 32'd0, 32'd10, 32'd0, 32'd1000, 32'd0);
        tick(); tick();
        send_word(32'hDEAD);
        chk("ovr_pulse", overrun, 1);
        chk("ovr_mod_kept", core_mod, 64'd1000);
        chk("ovr_still_waiting", word_out_valid, 0);
        tick();
        chk("ovr_pulse_end", overrun, 0);
        chk("ovr_busy", busy, 1);
        core_reply(64'h18);
        chk("ovr_word0", word_out, 32'h18);
        word_out_ready = 1'b1;
        tick();
        chk("ovr_word1", word_out, 32'h0);
        tick();
        word_out_ready = 1'b0;
        chk("ovr_done", word_out_valid, 0);

        // Reset mid-load
        send_word(32'd9); send_word(32'd0); send_word(32'd4);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_base", core_base, 0);
        chk("mid_rst_exp", core_exp, 0);
        chk("mid_rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        load6(32'h11, 32'd0, 32'h22, 32'd0, 32'h33, 32'd0);
        chk("mid_rst_start_lat1", core_start, 0);
        tick();
        chk("mid_rst_start", core_start, 1);
        chk("mid_rst_base_new", core_base, 64'h11);
        chk("mid_rst_mod_new", core_mod, 64'h33);
        core_reply(64'h5);
        word_out_ready = 1'b1;
        tick(); tick();
        word_out_ready = 1'b0;
        chk("mid_rst_drained", word_out_valid, 0);

        // Spurious done during LOAD_EXP
        send_word(32'd1); send_word(32'd0);
        core_reply(64'hFFFF);
        chk("spur_valid", word_out_valid, 0);
        chk("spur_busy", busy, 1);
        send_word(32'd2); send_word(32'd0); send_word(32'd3);
        chk("spur_no_early_start", busy, 1);
        send_word(32'd0);
        tick();
        chk("spur_start", core_start, 1);
        chk("spur_exp", core_exp, 64'd2);
        chk("spur_mod", core_mod, 64'd3);
        core_reply(64'h7);
        chk("spur_result", word_out, 32'h7);
        word_out_ready = 1'b1;
        tick(); tick();
        word_out_ready = 1'b0;

`ifdef RSA_OPSEQ_TIMEOUT_EN
        begin
            int waited;
            waited = 0;
            send_word(32'hAB);
            while (frame_error !== 1'b1 && waited < 130) begin
                tick();
                waited++;
            end
            chk("to_waited", waited, 101);
            chk("to_busy", busy, 0);
            tick();
            chk("to_pulse_end", frame_error, 0);
            load6(32'd4, 32'd0, 32'd5, 32'd0, 32'd6, 32'd0);
            tick();
            chk("to_start", core_start, 1);
            chk("to_base", core_base, 64'd4);
            core_reply(64'h9);
            word_out_ready = 1'b1;
            tick(); tick();
            word_out_ready = 1'b0;
            chk("to_drained", word_out_valid, 0);
        end
`else
        repeat (20) tick();
        chk("no_to_frame_error", frame_error, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
